// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: active-low segment
// patterns {A..G}, conversion FSM states and small elaboration helpers.
package seg_pkg;

   localparam logic [6:0] SEG_0    = 7'h01;
   localparam logic [6:0] SEG_1    = 7'h4F;
   localparam logic [6:0] SEG_2    = 7'h12;
   localparam logic [6:0] SEG_3    = 7'h06;
   localparam logic [6:0] SEG_4    = 7'h4C;
   localparam logic [6:0] SEG_5    = 7'h24;
   localparam logic [6:0] SEG_6    = 7'h20;
   localparam logic [6:0] SEG_7    = 7'h0F;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h04;
   localparam logic [6:0] SEG_DASH = 7'h7E;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } conv_state_e;

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // Non-BCD nibbles cannot occur from the converter; they fall back to dark.
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle for
// DATA_W cycles after start_i, then a one-cycle done_o pulse.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int NUM_DIGITS = 2
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [DATA_W-1:0]       bin_i,
   output logic                    done_o,
   output logic [4*NUM_DIGITS-1:0] bcd_o,
   output logic                    ovf_o
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(pow10(NUM_DIGITS) - 1);

   logic [DATA_W-1:0] bin_q;
   logic [BCD_W-1:0]  bcd_q;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt_q;
   logic              active_q;
   logic              done_q;
   logic              ovf_q;

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign bcd_adj = add3(bcd_q);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         active_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
         end else if (active_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               active_q <= 1'b0;
               done_q   <= 1'b1;
            end
         end
      end
   end

   // Bits shifted out of the top digit are irrelevant: overflow is decided
   // directly from the binary value and forces dashes downstream.
   always_ff @(posedge clock_i) begin
      if (start_i) begin
         bin_q <= bin_i;
         bcd_q <= '0;
         ovf_q <= (bin_i > MAX_VAL);
      end else if (active_q) begin
         bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
         bin_q <= {bin_q[DATA_W-2:0], 1'b0};
      end
   end

   assign done_o = done_q;
   assign bcd_o  = bcd_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed N-digit 7-segment driver: accepts a binary value by valid/ready,
// converts it to BCD, and scans digits MSD-first with an anti-ghost blank.
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int DATA_W       = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic                  blank_lz,
   output logic [6:0]            out_cathode,
   output logic [NUM_DIGITS-1:0] anode
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   conv_state_e           state_q;
   logic                  ready_q;
   logic [BCD_W-1:0]      pend_q;
   logic                  pend_ovf_q;
   logic [BCD_W-1:0]      disp_q;
   logic                  disp_ovf_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [NUM_DIGITS-1:0] anode_q;
   logic [NUM_DIGITS-1:0] anode_d;
   logic [6:0]            cath_q;
   logic [6:0]            cath_d;

   logic                  accept;
   logic                  slot_wrap;
   logic                  conv_done;
   logic                  conv_ovf;
   logic [BCD_W-1:0]      conv_bcd;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  lz_run;
   logic [3:0]            cur_digit;

   // ready_q is high only in IDLE, so this also gates acceptance to IDLE.
   assign accept = data_valid & ready_q;

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clock_i (clock),
      .reset_i (reset),
      .start_i (accept),
      .bin_i   (data_in),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd),
      .ovf_o   (conv_ovf)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         pend_q     <= '0;
         pend_ovf_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= CONV;
                  ready_q <= 1'b0;
               end
            end
            CONV: begin
               if (conv_done) state_q <= COMMIT;
            end
            COMMIT: begin
               pend_q     <= conv_bcd;
               pend_ovf_q <= conv_ovf;
               state_q    <= IDLE;
               ready_q    <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign slot_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

   // Display register only changes on a slot boundary, never mid-digit.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
         disp_ovf_q <= 1'b0;
         anode_q    <= '0;
         cath_q     <= SEG_OFF;
      end else begin
         anode_q <= anode_d;
         cath_q  <= cath_d;
         if (slot_wrap) begin
            cnt_q      <= '0;
            idx_q      <= (idx_q == '0) ? IDX_W'(NUM_DIGITS - 1) : idx_q - 1'b1;
            disp_q     <= pend_q;
            disp_ovf_q <= pend_ovf_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      lz_run   = 1'b1;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lz_run      = lz_run & (disp_q[4*i +: 4] == 4'd0);
         lz_blank[i] = lz_run;
      end
      cur_digit = disp_q[{idx_q, 2'b00} +: 4];
      anode_d   = '0;
      cath_d    = SEG_OFF;
      if (cnt_q >= CNT_W'(BLANK_CYCLES)) begin
         anode_d[idx_q] = 1'b1;
         if (disp_ovf_q)                       cath_d = SEG_DASH;
         else if (blank_lz && lz_blank[idx_q]) cath_d = SEG_OFF;
         else                                  cath_d = seg_encode(cur_digit);
      end
   end

   assign data_ready  = ready_q;
   assign anode       = anode_q;
   assign out_cathode = cath_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed + randomized bench for seg_scan_controller with an arithmetic
// reference model of the expected pattern for each digit position.
module tb_seg_scan_controller;

   localparam int ND   = 2;
   localparam int DW   = 8;
   localparam int RD   = 8;
   localparam int BC   = 2;
   localparam int MAXV = (10 ** ND) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          data_valid = 1'b0;
   logic          blank_lz = 1'b0;
   logic          data_ready;
   logic [6:0]    out_cathode;
   logic [ND-1:0] anode;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   seg_scan_controller #(
      .NUM_DIGITS   (ND),
      .DATA_W       (DW),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .blank_lz    (blank_lz),
      .out_cathode (out_cathode),
      .anode       (anode)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [6:0] digit_seg(input int d);
      case (d)
         0: return 7'h01;
         1: return 7'h4F;
         2: return 7'h12;
         3: return 7'h06;
         4: return 7'h4C;
         5: return 7'h24;
         6: return 7'h20;
         7: return 7'h0F;
         8: return 7'h00;
         default: return 7'h04;
      endcase
   endfunction

   // Pattern expected on the cathodes while digit position pos is lit.
   function automatic logic [6:0] model_seg(input int v, input bit blz, input int pos);
      int scale;
      scale = 1;
      for (int k = 0; k < pos; k++) scale = scale * 10;
      if (v > MAXV) return 7'h7E;
      if (blz && pos > 0 && v < scale) return 7'h7F;
      return digit_seg((v / scale) % 10);
   endfunction

   function automatic int anode_pos(input logic [ND-1:0] a);
      int p;
      p = -1;
      for (int i = 0; i < ND; i++) if (a[i]) p = i;
      return p;
   endfunction

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_anode(input bit lit, input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 2 * RD + 4; k++) begin
         @(negedge clock);
         if ((anode != '0) == lit) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic count_ready_low(output int n);
      bit back;
      back = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (data_ready) begin
            back = 1'b1;
            break;
         end
         n++;
      end
      if (!back) check("ready_return_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input int v, input string tag);
      int low;
      data_in    = DW'(v);
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      count_ready_low(low);
      check({tag, "_ready_low"}, low, 10);
   endtask

   task automatic observe_slots(input int v, input bit blz, input string tag);
      int pos;
      int prev;
      prev = 0;
      for (int s = 0; s < 2 * ND; s++) begin
         wait_anode(1'b0, tag);
         wait_anode(1'b1, tag);
         pos = anode_pos(anode);
         check({tag, "_cathode"}, out_cathode, model_seg(v, blz, pos));
         if (s > 0) check({tag, "_order"}, pos, (prev == 0) ? ND - 1 : prev - 1);
         prev = pos;
      end
   endtask

   // Scan-shape checker: never multi-hot, fixed blank and lit lengths per slot.
   initial begin
      int zrun;
      int nzrun;
      bit prev_lit;
      bit run_valid;
      zrun = 0; nzrun = 0; prev_lit = 1'b0; run_valid = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            zrun = 0; nzrun = 0; prev_lit = 1'b0; run_valid = 1'b0;
         end else begin
            check("anode_onehot0", $onehot0(anode), 1);
            if (anode == '0) begin
               if (prev_lit && run_valid) check("lit_len", nzrun, RD - BC);
               nzrun = 0;
               zrun++;
               prev_lit = 1'b0;
            end else begin
               if (!prev_lit) begin
                  if (run_valid) check("blank_len", zrun, BC);
                  run_valid = 1'b1;
               end
               zrun = 0;
               nzrun++;
               prev_lit = 1'b1;
            end
         end
      end
   end

   initial begin
      int low;
      int v;
      bit blz;

      // Reset values
      repeat (3) tick();
      @(negedge clock);
      check("rst_anode", anode, 0);
      check("rst_cathode", out_cathode, 7'h7F);
      check("rst_ready", data_ready, 1);
      tick();
      reset = 1'b0;

      wait_anode(1'b1, "first_slot");
      check("first_slot_anode", anode, 2'b01);
      check("first_slot_cathode", out_cathode, 7'h01);
      observe_slots(0, 1'b0, "init00");

      send(23, "d23");
      repeat (RD + 2) tick();
      observe_slots(23, 1'b0, "d23");

      send(150, "d150");
      repeat (RD + 2) tick();
      observe_slots(150, 1'b0, "d150");

      blank_lz = 1'b1;
      send(5, "d5lz");
      repeat (RD + 2) tick();
      observe_slots(5, 1'b1, "d5lz");

      send(0, "d0lz");
      repeat (RD + 2) tick();
      observe_slots(0, 1'b1, "d0lz");

      // Back-to-back: valid stays high across the busy window
      blank_lz   = 1'b0;
      data_in    = 8'd24;
      data_valid = 1'b1;
      tick();
      data_in = 8'd25;
      count_ready_low(low);
      check("b2b_first_low", low, 10);
      tick();
      data_valid = 1'b0;
      count_ready_low(low);
      check("b2b_second_low", low, 10);
      repeat (RD + 2) tick();
      observe_slots(25, 1'b0, "b2b25");

      // Reset mid-conversion aborts 99
      data_in    = 8'd99;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (2) tick();
      @(negedge clock);
      check("midrst_anode", anode, 0);
      check("midrst_cathode", out_cathode, 7'h7F);
      check("midrst_ready", data_ready, 1);
      tick();
      reset = 1'b0;
      wait_anode(1'b1, "midrst_first");
      check("midrst_first_anode", anode, 2'b01);
      check("midrst_first_cathode", out_cathode, 7'h01);
      observe_slots(0, 1'b0, "midrst00");

      // Randomized values and blanking mode
      for (int r = 0; r < 8; r++) begin
         v   = int'($urandom_range(0, 130));
         blz = 1'($urandom_range(0, 1));
         blank_lz = blz;
         send(v, "rand");
         repeat (RD + 2) tick();
         observe_slots(v, blz, "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
